// File: rtl/account_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : account_access_arbiter_if
// Brief    : Requester and account-store signal bundle for the arbiter.
// Revision : 1.0
// ============================================================================
interface account_access_arbiter_if #(
    parameter int NUM_PORTS     = 4,
    parameter int CARD_WIDTH    = 6,
    parameter int BALANCE_WIDTH = 20
);
    logic [NUM_PORTS-1:0]               req;
    logic [NUM_PORTS-1:0]               req_we;
    logic [NUM_PORTS*CARD_WIDTH-1:0]    req_card;
    logic [NUM_PORTS*BALANCE_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]               grant;
    logic [NUM_PORTS-1:0]               ack;
    logic [BALANCE_WIDTH-1:0]           rdata;
    logic                               busy;
    logic [CARD_WIDTH-1:0]              mem_addr;
    logic                               mem_re;
    logic                               mem_we;
    logic [BALANCE_WIDTH-1:0]           mem_wdata;
    logic [BALANCE_WIDTH-1:0]           mem_rdata;

    modport master (
        output req, req_we, req_card, req_wdata, mem_rdata,
        input  grant, ack, rdata, busy, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req, req_we, req_card, req_wdata, mem_rdata,
        output grant, ack, rdata, busy, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/account_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : account_access_arbiter
// Brief    : Round-robin arbiter serialising ATM sessions onto one account store.
// Revision : 1.0
// ============================================================================
module account_access_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int CARD_WIDTH    = 6,
    parameter int BALANCE_WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    account_access_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [IDX_W-1:0]         winner_q, winner_d;
    logic                     we_q, we_d;
    logic [NUM_PORTS-1:0]     grant_q, grant_d;
    logic [NUM_PORTS-1:0]     ack_q, ack_d;
    logic                     busy_q, busy_d;
    logic                     mem_re_q, mem_re_d;
    logic                     mem_we_q, mem_we_d;
    logic [CARD_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [BALANCE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BALANCE_WIDTH-1:0] rdata_q, rdata_d;

    logic                     found;
    logic [IDX_W-1:0]         pick;

    // Search starts just past the last served port so the previous owner ends up lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && bus.req[(int'(last_q) + 1 + k) % NUM_PORTS]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(last_q) + 1 + k) % NUM_PORTS);
            end
        end
    end

    // Outputs are computed for the state being entered so they appear registered.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        winner_d    = winner_q;
        we_d        = we_q;
        grant_d     = grant_q;
        ack_d       = '0;
        busy_d      = busy_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = ACCESS;
                    winner_d    = pick;
                    we_d        = bus.req_we[pick];
                    grant_d     = ONE_HOT0 << pick;
                    busy_d      = 1'b1;
                    mem_addr_d  = bus.req_card[int'(pick)*CARD_WIDTH +: CARD_WIDTH];
                    mem_wdata_d = bus.req_wdata[int'(pick)*BALANCE_WIDTH +: BALANCE_WIDTH];
                    mem_we_d    = bus.req_we[pick];
                    mem_re_d    = !bus.req_we[pick];
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                    ack_d   = grant_q;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rdata_d = bus.mem_rdata;
                state_d = DONE;
                ack_d   = grant_q;
            end
            DONE: begin
                last_d  = winner_q;
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= LAST_RESET;
            winner_q    <= '0;
            we_q        <= 1'b0;
            grant_q     <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            we_q        <= we_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_account_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_account_access_arbiter
// Brief    : Scoreboard bench for the account access arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_account_access_arbiter;
    localparam int NP = 4;
    localparam int CW = 6;
    localparam int BW = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    account_access_arbiter_if #(.NUM_PORTS(NP), .CARD_WIDTH(CW), .BALANCE_WIDTH(BW)) bus();

    account_access_arbiter #(.NUM_PORTS(NP), .CARD_WIDTH(CW), .BALANCE_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Account store model: data returns the cycle after the read strobe.
    logic [BW-1:0] store [0:63];
    always @(posedge clk) begin
        if (bus.mem_we) store[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= store[bus.mem_addr];
    end

    typedef struct {
        int          port;
        bit          we;
        logic [BW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    task automatic push_exp(input int p, input bit we, input logic [BW-1:0] d);
        exp_t e;
        e.port = p;
        e.we   = we;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_port(input int p, input bit r, input bit we,
                            input logic [CW-1:0] card, input logic [BW-1:0] wd);
        bus.req[p]                = r;
        bus.req_we[p]             = we;
        bus.req_card[p*CW +: CW]  = card;
        bus.req_wdata[p*BW +: BW] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0; bus.req_we = '0; bus.req_card = '0; bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.grant, bus.ack, bus.busy, bus.mem_re, bus.mem_we} !== '0)
            $display("FAIL reset_ctrl got grant=%b ack=%b busy=%b re=%b we=%b want all 0",
                     bus.grant, bus.ack, bus.busy, bus.mem_re, bus.mem_we);
        else n_pass++;
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0)
            $display("FAIL reset_data got addr=%0d wdata=%0d rdata=%0d want 0",
                     bus.mem_addr, bus.mem_wdata, bus.rdata);
        else n_pass++;
        bus.req = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (bus.grant !== 4'b0000) $display("FAIL reset_hold_grant got %b want 0000", bus.grant);
        else n_pass++;
        bus.req = '0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_single_read();
        exp_t e;
        @(negedge clk);
        set_port(2, 1'b1, 1'b0, 6'd5, '0);
        push_exp(2, 1'b0, 20'd1000);
        @(negedge clk);
        n_checks++;
        if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 6'd5 || bus.grant !== 4'b0100)
            $display("FAIL read_access got re=%b we=%b addr=%0d grant=%b want re=1 we=0 addr=5 grant=0100",
                     bus.mem_re, bus.mem_we, bus.mem_addr, bus.grant);
        else n_pass++;
        bus.req[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.grant !== 4'b0100 || bus.ack !== 4'b0000 || bus.mem_re !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL read_wait got grant=%b ack=%b re=%b busy=%b want 0100 0000 0 1",
                     bus.grant, bus.ack, bus.mem_re, bus.busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) $display("FAIL read_done scoreboard empty ack=%b", bus.ack);
        else begin
            e = sb.pop_front();
            if (bus.ack !== (4'b0001 << e.port) || bus.rdata !== e.data || bus.grant !== 4'b0100)
                $display("FAIL read_done got ack=%b rdata=%0d grant=%b want ack=%b rdata=%0d grant=0100",
                         bus.ack, bus.rdata, bus.grant, 4'b0001 << e.port, e.data);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.grant !== 4'b0000)
            $display("FAIL read_after got ack=%b busy=%b grant=%b want 0000 0 0000", bus.ack, bus.busy, bus.grant);
        else n_pass++;
    endtask

    task automatic test_single_write();
        exp_t e;
        set_port(1, 1'b1, 1'b1, 6'd9, 20'd250);
        push_exp(1, 1'b1, 20'd250);
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 6'd9 || bus.mem_wdata !== 20'd250)
            $display("FAIL write_access got we=%b re=%b addr=%0d wdata=%0d want 1 0 9 250",
                     bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        set_port(1, 1'b0, 1'b0, 6'd0, 20'd0);
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) $display("FAIL write_done scoreboard empty ack=%b", bus.ack);
        else begin
            e = sb.pop_front();
            if (bus.ack !== (4'b0001 << e.port) || bus.rdata !== 20'd1000 || bus.mem_we !== 1'b0 || bus.mem_addr !== 6'd9)
                $display("FAIL write_done got ack=%b rdata=%0d we=%b addr=%0d want ack=%b rdata=1000 we=0 addr=9",
                         bus.ack, bus.rdata, bus.mem_we, bus.mem_addr, 4'b0001 << e.port);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (store[9] !== 20'd250 || bus.rdata !== 20'd1000)
            $display("FAIL write_store got store9=%0d rdata=%0d want 250 1000", store[9], bus.rdata);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int got = 0;
        bit prev_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b0, CW'(10 + i), '0);
        for (int i = 0; i < 5; i++) push_exp(i % NP, 1'b0, BW'(100 * (i % NP) + 7));
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (!$onehot0(bus.grant) || (bus.mem_re && bus.mem_we) || (prev_ack && bus.busy))
                $display("FAIL rr_invariant got grant=%b re=%b we=%b busy=%b prev_ack=%b",
                         bus.grant, bus.mem_re, bus.mem_we, bus.busy, prev_ack);
            else n_pass++;
            prev_ack = (bus.ack != '0);
            if (bus.ack != '0) begin
                n_checks++;
                got++;
                if (sb.size() == 0) $display("FAIL rr_ack unexpected ack=%b", bus.ack);
                else begin
                    e = sb.pop_front();
                    if (bus.ack !== (4'b0001 << e.port) || bus.rdata !== e.data)
                        $display("FAIL rr_ack got ack=%b rdata=%0d want ack=%b rdata=%0d",
                                 bus.ack, bus.rdata, 4'b0001 << e.port, e.data);
                    else n_pass++;
                end
            end
        end
        bus.req = '0;
        n_checks++;
        if (got != 5) $display("FAIL rr_timeout got %0d acks want 5", got);
        else n_pass++;
        repeat (2) @(negedge clk);
        sb.delete();
    endtask

    task automatic test_same_card();
        exp_t e;
        int got = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_port(0, 1'b1, 1'b1, 6'd3, 20'd777);
        set_port(3, 1'b1, 1'b0, 6'd3, 20'd0);
        push_exp(0, 1'b1, 20'd777);
        push_exp(3, 1'b0, 20'd777);
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                n_checks++;
                got++;
                if (sb.size() == 0) $display("FAIL same_card unexpected ack=%b", bus.ack);
                else begin
                    e = sb.pop_front();
                    if (bus.ack !== (4'b0001 << e.port) || (!e.we && bus.rdata !== e.data))
                        $display("FAIL same_card got ack=%b rdata=%0d want ack=%b rdata=%0d",
                                 bus.ack, bus.rdata, 4'b0001 << e.port, e.data);
                    else n_pass++;
                    bus.req[e.port] = 1'b0;
                end
            end
        end
        n_checks++;
        if (got != 2) $display("FAIL same_card_timeout got %0d acks want 2", got);
        else n_pass++;
        repeat (2) @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int got = 0;
        set_port(2, 1'b1, 1'b0, 6'd5, '0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.grant !== 4'b0100 || bus.busy !== 1'b1 || bus.mem_re !== 1'b0)
            $display("FAIL abort_pre got grant=%b busy=%b re=%b want 0100 1 0", bus.grant, bus.busy, bus.mem_re);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.grant, bus.ack, bus.busy, bus.mem_re, bus.mem_we} !== '0 || bus.rdata !== '0 || bus.mem_addr !== '0)
            $display("FAIL abort_async got grant=%b ack=%b busy=%b rdata=%0d addr=%0d want all 0",
                     bus.grant, bus.ack, bus.busy, bus.rdata, bus.mem_addr);
        else n_pass++;
        set_port(0, 1'b1, 1'b0, 6'd10, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ack !== 4'b0000 || bus.mem_re !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL abort_hold got ack=%b re=%b busy=%b want 0000 0 0", bus.ack, bus.mem_re, bus.busy);
            else n_pass++;
        end
        push_exp(0, 1'b0, 20'd7);
        push_exp(2, 1'b0, 20'd1000);
        rst = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                n_checks++;
                got++;
                if (sb.size() == 0) $display("FAIL abort_rearb unexpected ack=%b", bus.ack);
                else begin
                    e = sb.pop_front();
                    if (bus.ack !== (4'b0001 << e.port) || bus.rdata !== e.data)
                        $display("FAIL abort_rearb got ack=%b rdata=%0d want ack=%b rdata=%0d",
                                 bus.ack, bus.rdata, 4'b0001 << e.port, e.data);
                    else n_pass++;
                    bus.req[e.port] = 1'b0;
                end
            end
        end
        n_checks++;
        if (got != 2) $display("FAIL abort_timeout got %0d acks want 2", got);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) store[a] = '0;
        store[5] = 20'd1000;
        for (int i = 0; i < NP; i++) store[10 + i] = BW'(100 * i + 7);
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_same_card();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
